motor_encoder_emulator: RTL and testbench

Hardware-in-the-loop stand-in for a DC motor with a quadrature encoder. It consumes the PWM and DIR outputs that the wheel controller drives. It produces the encoder A/B signals the wheel controller consumes, so the speed loop can be closed on the FPGA without a motor. Duty is measured over fixed windows and converted to an encoder edge rate by a phase accumulator. A Gray-code state machine then steps the A/B outputs forward or reverse.

---
 rtl/motor_encoder_emulator_if.sv | 35 +++
 rtl/motor_encoder_emulator.sv | 193 +++++++++++++++++++
 tb/tb_motor_encoder_emulator.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_encoder_emulator_if.sv
// Encoder-emulator signal bundle.
// The controller side uses the master modport: it drives PWM/DIR and
// receives A/B, STEP, DUTY and POS. The emulator uses the slave modport.
interface motor_encoder_emulator_if #(
    parameter int WINDOW_BITS = 12,
    parameter int POS_WIDTH   = 17
);
    logic                   MOTOR_EMU_PWM_In;
    logic [1:0]             MOTOR_EMU_DIR_InBus;
    logic                   MOTOR_EMU_ENCODERA_Out;
    logic                   MOTOR_EMU_ENCODERB_Out;
    logic                   MOTOR_EMU_STEP_Out;
    logic [WINDOW_BITS-1:0] MOTOR_EMU_DUTY_OutBus;
    logic [POS_WIDTH-1:0]   MOTOR_EMU_POS_OutBus;

    modport master (
        output MOTOR_EMU_PWM_In,
        output MOTOR_EMU_DIR_InBus,
        input  MOTOR_EMU_ENCODERA_Out,
        input  MOTOR_EMU_ENCODERB_Out,
        input  MOTOR_EMU_STEP_Out,
        input  MOTOR_EMU_DUTY_OutBus,
        input  MOTOR_EMU_POS_OutBus
    );

    modport slave (
        input  MOTOR_EMU_PWM_In,
        input  MOTOR_EMU_DIR_InBus,
        output MOTOR_EMU_ENCODERA_Out,
        output MOTOR_EMU_ENCODERB_Out,
        output MOTOR_EMU_STEP_Out,
        output MOTOR_EMU_DUTY_OutBus,
        output MOTOR_EMU_POS_OutBus
    );
endinterface

// File: rtl/motor_encoder_emulator.sv
// DC motor + quadrature encoder emulator.
// PWM duty is measured over 2^WINDOW_BITS-clock windows, turned into an
// edge rate by a phase accumulator, and each accumulator carry steps a
// Gray-code A/B state machine forward or reverse.
// Optional build macro MOTOR_EMU_INERTIA_EN: the effective rate slews toward
// the latched duty by at most RAMP_STEP per window instead of following it.
module motor_encoder_emulator #(
    parameter int WINDOW_BITS = 12,
    parameter int ACC_WIDTH   = 16,
    parameter int POS_WIDTH   = 17,
    parameter int RAMP_STEP   = 64
) (
    input  logic                        MOTOR_EMU_CLOCK,
    input  logic                        MOTOR_EMU_RESET_InHigh,
    motor_encoder_emulator_if.slave     bus
);
    localparam logic [WINDOW_BITS-1:0] WIN_MAX = {WINDOW_BITS{1'b1}};

    // Encoding chosen so that the state value is directly {A, B}.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b10,
        S2 = 2'b11,
        S3 = 2'b01
    } quad_t;

    logic clk;
    logic srst;
    assign clk  = MOTOR_EMU_CLOCK;
    assign srst = MOTOR_EMU_RESET_InHigh;

    // Input synchronizers: bit 0 is PWM, bits 2:1 are DIR.
    logic [2:0] raw_in;
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;
    assign raw_in = {bus.MOTOR_EMU_DIR_InBus, bus.MOTOR_EMU_PWM_In};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            // Two-flop synchronizer per asynchronous input bit; left unreset so
            // the inputs are already settled when reset is released.
            always_ff @(posedge clk) begin
                meta_reg[gi] <= raw_in[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    endgenerate

    logic       pwm_s;
    logic [1:0] dir_s;
    logic       fwd;
    logic       rev;
    logic       moving;
    assign pwm_s  = sync_reg[0];
    assign dir_s  = sync_reg[2:1];
    assign fwd    = (dir_s == 2'b10);
    assign rev    = (dir_s == 2'b01);
    assign moving = fwd | rev;

    // Duty measurement
    logic [WINDOW_BITS-1:0] window_reg;
    logic [WINDOW_BITS-1:0] high_reg;
    logic [WINDOW_BITS-1:0] duty_reg;
    logic [WINDOW_BITS-1:0] high_next;
    logic                   window_end;

    assign window_end = (window_reg == WIN_MAX);
    assign high_next  = (pwm_s && (high_reg != WIN_MAX)) ? high_reg + 1'b1 : high_reg;

    // Free-running window; latch the saturated high count at the last cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            window_reg <= '0;
            high_reg   <= '0;
            duty_reg   <= '0;
        end else begin
            window_reg <= window_reg + 1'b1;
            if (window_end) begin
                duty_reg <= high_next;
                high_reg <= '0;
            end else begin
                high_reg <= high_next;
            end
        end
    end

    logic [ACC_WIDTH-1:0] rate_eff;

`ifdef MOTOR_EMU_INERTIA_EN
    localparam logic [ACC_WIDTH-1:0] RAMP = ACC_WIDTH'(RAMP_STEP);

    logic [ACC_WIDTH-1:0] rate_reg;
    logic [ACC_WIDTH-1:0] rate_next;
    logic [ACC_WIDTH-1:0] ramp_target;

    // Slew toward the newly latched duty, landing exactly once within RAMP.
    always_comb begin
        ramp_target = ACC_WIDTH'(high_next);
        rate_next   = rate_reg;
        if (!moving) begin
            rate_next = '0;
        end else if (window_end) begin
            if (rate_reg < ramp_target) begin
                rate_next = (ramp_target - rate_reg > RAMP) ? rate_reg + RAMP : ramp_target;
            end else begin
                rate_next = (rate_reg - ramp_target > RAMP) ? rate_reg - RAMP : ramp_target;
            end
        end
    end

    // Effective-rate register; brake drops it to zero at once.
    always_ff @(posedge clk) begin
        if (srst) begin
            rate_reg <= '0;
        end else begin
            rate_reg <= rate_next;
        end
    end

    assign rate_eff = rate_reg;
`else
    assign rate_eff = ACC_WIDTH'(duty_reg);
`endif

    // Phase accumulator: a carry out of the sum requests one step.
    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 step_req;

    assign acc_sum  = {1'b0, acc_reg} + {1'b0, rate_eff};
    assign step_req = moving & acc_sum[ACC_WIDTH];

    // Accumulate while driven; hold at zero while braking.
    always_ff @(posedge clk) begin
        if (srst) begin
            acc_reg <= '0;
        end else if (moving) begin
            acc_reg <= acc_sum[ACC_WIDTH-1:0];
        end else begin
            acc_reg <= '0;
        end
    end

    // Quadrature state machine
    quad_t                state_reg;
    quad_t                state_next;
    logic                 step_reg;
    logic [POS_WIDTH-1:0] pos_reg;

    // Next Gray state from the current state and synchronized direction.
    always_comb begin
        state_next = state_reg;
        if (step_req) begin
            if (fwd) begin
                case (state_reg)
                    S0:      state_next = S1;
                    S1:      state_next = S2;
                    S2:      state_next = S3;
                    default: state_next = S0;
                endcase
            end else begin
                case (state_reg)
                    S0:      state_next = S3;
                    S3:      state_next = S2;
                    S2:      state_next = S1;
                    default: state_next = S0;
                endcase
            end
        end
    end

    // State, step pulse and signed position all update on the same edge.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= S0;
            step_reg  <= 1'b0;
            pos_reg   <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_req;
            if (step_req) begin
                pos_reg <= fwd ? pos_reg + POS_WIDTH'(1) : pos_reg - POS_WIDTH'(1);
            end
        end
    end

    assign bus.MOTOR_EMU_ENCODERA_Out = state_reg[1];
    assign bus.MOTOR_EMU_ENCODERB_Out = state_reg[0];
    assign bus.MOTOR_EMU_STEP_Out     = step_reg;
    assign bus.MOTOR_EMU_DUTY_OutBus  = duty_reg;
    assign bus.MOTOR_EMU_POS_OutBus   = pos_reg;
endmodule

// File: tb/tb_motor_encoder_emulator.sv
// Scoreboard bench for motor_encoder_emulator: each phase pushes its
// expected results when its stimulus is applied, then pops and compares
// them against what the encoder outputs did.
`timescale 1ns/1ps
module tb_motor_encoder_emulator;
    logic clk = 1'b0;
    logic srst = 1'b1;
    int   pwm_mode = 1;          // 0 low, 1 high, 2 50% of a 256-clock period
    int   checks = 0;
    int   errors = 0;

    motor_encoder_emulator_if #(.WINDOW_BITS(12), .POS_WIDTH(17)) bus ();

    motor_encoder_emulator #(
        .WINDOW_BITS(12), .ACC_WIDTH(16), .POS_WIDTH(17), .RAMP_STEP(64)
    ) dut (
        .MOTOR_EMU_CLOCK        (clk),
        .MOTOR_EMU_RESET_InHigh (srst),
        .bus                    (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        string tag;
        int    value;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic expect_push(input string tag, input int value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic expect_pop(input int observed);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
        end else begin
            e = sb_q.pop_front();
            $display("txn %s: observed %0d, expected %0d", e.tag, observed, e.value);
            check(e.tag, observed, e.value);
        end
    endtask

    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] cur_ab();
        return {bus.MOTOR_EMU_ENCODERA_Out, bus.MOTOR_EMU_ENCODERB_Out};
    endfunction

    function automatic int cur_pos();
        return int'($signed(bus.MOTOR_EMU_POS_OutBus));
    endfunction

    // PWM source, updated on the falling edge.
    initial begin
        int ph;
        ph = 0;
        bus.MOTOR_EMU_PWM_In = 1'b1;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 256;
            case (pwm_mode)
                0:       bus.MOTOR_EMU_PWM_In = 1'b0;
                1:       bus.MOTOR_EMU_PWM_In = 1'b1;
                default: bus.MOTOR_EMU_PWM_In = (ph < 128);
            endcase
        end
    end

    // Observe n cycles. want: 1 forward only, -1 reverse only, 0 either,
    // 2 no steps allowed. gap != 0 demands that spacing between steps.
    int w_steps, w_bad, w_gap_bad;
    task automatic watch(input int n, input int want, input int gap);
        logic [1:0] pab, cab;
        int ppos, cpos, last;
        bit okf, okr, ok;
        pab = cur_ab(); ppos = cur_pos(); last = -1;
        w_steps = 0; w_bad = 0; w_gap_bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cab = cur_ab(); cpos = cur_pos();
            if (bus.MOTOR_EMU_STEP_Out) begin
                w_steps++;
                okf = (cab == fwd_next(pab)) && (cpos == ppos + 1);
                okr = (cab == rev_next(pab)) && (cpos == ppos - 1);
                case (want)
                    1:       ok = okf;
                    -1:      ok = okr;
                    2:       ok = 1'b0;
                    default: ok = okf | okr;
                endcase
                if (!ok) w_bad++;
                if (gap != 0 && last >= 0 && (i - last) != gap) w_gap_bad++;
                last = i;
            end else if (cab != pab || cpos != ppos) begin
                w_bad++;
            end
            pab = cab; ppos = cpos;
        end
    endtask

    task automatic wait_duty(input int value, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(bus.MOTOR_EMU_DUTY_OutBus) != value && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(bus.MOTOR_EMU_DUTY_OutBus), value);
    endtask

    initial begin
        #1_950_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, nz, st;
        logic [1:0] held_ab;
        bus.MOTOR_EMU_DIR_InBus = 2'b10;
        srst = 1'b1;
        pwm_mode = 1;

        // Reset held 5 clocks, then the first cycle after release.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            expect_push($sformatf("reset_outputs_%0d", i), 0);
            expect_pop({bus.MOTOR_EMU_ENCODERA_Out, bus.MOTOR_EMU_ENCODERB_Out,
                        bus.MOTOR_EMU_STEP_Out, bus.MOTOR_EMU_POS_OutBus,
                        bus.MOTOR_EMU_DUTY_OutBus} != 0);
            if (i == 4) srst = 1'b0;
        end

`ifdef MOTOR_EMU_INERTIA_EN
        // Ramp from 0 by 64 per window under constant full duty.
        for (int k = 1; k <= 8; k++) begin
            repeat (k == 1 ? 4095 : 4096) @(negedge clk);
            expect_push($sformatf("ramp_rate_w%0d", k), 64 * k);
            expect_pop(int'(dut.rate_eff));
        end
        bus.MOTOR_EMU_DIR_InBus = 2'b00;
        repeat (3) @(negedge clk);
        expect_push("brake_rate", 0);
        expect_pop(int'(dut.rate_eff));
        expect_push("brake_steps", 0);
        expect_push("brake_bad", 0);
        watch(200, 2, 0);
        expect_pop(w_steps);
        expect_pop(w_bad);
`else
        // Full duty forward: exactly 4095 steps in 65536 clocks.
        wait_duty(4095, 5000, "full_duty_latch");
        expect_push("full_steps", 4095);
        expect_push("full_bad", 0);
        expect_push("full_pos", 4095);
        watch(65536, 1, 0);
        expect_pop(w_steps);
        expect_pop(w_bad);
        expect_pop(cur_pos());

        // 50% duty reverse: one step every 32 clocks.
        pwm_mode = 2;
        bus.MOTOR_EMU_DIR_InBus = 2'b01;
        wait_duty(2048, 10000, "half_duty_latch");
        p0 = cur_pos();
        expect_push("rev_steps", 40);
        expect_push("rev_bad", 0);
        expect_push("rev_gap_bad", 0);
        expect_push("rev_pos_delta", -40);
        watch(1280, -1, 32);
        expect_pop(w_steps);
        expect_pop(w_bad);
        expect_pop(w_gap_bad);
        expect_pop(cur_pos() - p0);

        // Reverse to forward without clearing the accumulator.
        bus.MOTOR_EMU_DIR_InBus = 2'b10;
        watch(8, 0, 0);
        expect_push("dirchg_bad", 0);
        expect_pop(w_bad);
        expect_push("fwd_steps", 20);
        expect_push("fwd_bad", 0);
        expect_push("fwd_gap_bad", 0);
        watch(640, 1, 32);
        expect_pop(w_steps);
        expect_pop(w_bad);
        expect_pop(w_gap_bad);

        // Brake freezes A/B and POS.
        bus.MOTOR_EMU_DIR_InBus = 2'b00;
        watch(4, 0, 0);
        held_ab = cur_ab();
        p0 = cur_pos();
        expect_push("brake_steps", 0);
        expect_push("brake_bad", 0);
        expect_push("brake_pos", p0);
        watch(300, 2, 0);
        expect_pop(w_steps);
        expect_pop(w_bad);
        expect_pop(cur_pos());
        expect_push("brake_ab", int'(held_ab));
        expect_pop(int'(cur_ab()));

        // Resume forward from the held state; accumulator restarts at 0.
        bus.MOTOR_EMU_DIR_InBus = 2'b10;
        expect_push("resume_steps", 3);
        expect_push("resume_bad", 0);
        watch(100, 1, 0);
        expect_pop(w_steps);
        expect_pop(w_bad);

        // One-clock reset while running forward.
        watch(50, 1, 0);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        expect_push("midrst_pos", 0);
        expect_push("midrst_ab", 0);
        expect_push("midrst_step", 0);
        expect_push("midrst_duty", 0);
        expect_pop(cur_pos());
        expect_pop(int'(cur_ab()));
        expect_pop(int'(bus.MOTOR_EMU_STEP_Out));
        expect_pop(int'(bus.MOTOR_EMU_DUTY_OutBus));
        nz = 0; st = 0;
        expect_push("postrst_duty_nonzero", 0);
        expect_push("postrst_steps", 0);
        for (int i = 0; i < 4095; i++) begin
            @(negedge clk);
            if (bus.MOTOR_EMU_DUTY_OutBus != 0) nz++;
            if (bus.MOTOR_EMU_STEP_Out) st++;
        end
        expect_pop(nz);
        expect_pop(st);
        @(negedge clk);
        expect_push("postrst_duty", 2048);
        expect_pop(int'(bus.MOTOR_EMU_DUTY_OutBus));
`endif

        check("scoreboard_leftover", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
